// File: rtl/aes_cipher_core_pkg.sv
// rtl/aes_cipher_core_pkg.sv - AES-128 cipher core constants, state encoding and GF(2^8) helpers
package aes_cipher_core_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_NR      = 10;
  localparam int AES_ADDR_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDKEY,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } aes_state_e;

  // multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // shift-and-add GF(2^8) multiply
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] m;
    p = 8'h00;
    x = a;
    m = b;
    for (int i = 0; i < 8; i++) begin
      if (m[0]) p = p ^ x;
      x = xtime(x);
      m = m >> 1;
    end
    return p;
  endfunction

  // multiplicative inverse as a^254 (square-and-multiply); 0 maps to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // one column through the {02,03,01,01} circulant, row 0 in the MSB byte
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_cipher_core_if.sv
// rtl/aes_cipher_core_if.sv - plaintext/ciphertext handshake and round-key read port bundle
interface aes_cipher_core_if
  import aes_cipher_core_pkg::*;
  ();

  logic                   key_ready;
  logic                   in_valid;
  logic                   in_ready;
  logic [AES_BLOCK_W-1:0] in_block;
  logic [AES_ADDR_W-1:0]  rk_addr;
  logic [AES_BLOCK_W-1:0] rk_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_BLOCK_W-1:0] out_block;
  logic                   busy;

  modport master (
    output key_ready, in_valid, in_block, rk_data, out_ready,
    input  in_ready, rk_addr, out_valid, out_block, busy
  );

  modport slave (
    input  key_ready, in_valid, in_block, rk_data, out_ready,
    output in_ready, rk_addr, out_valid, out_block, busy
  );

endinterface

// File: rtl/aes_cipher_core_round.sv
// rtl/aes_cipher_core_round.sv - one combinational AES encryption round
module aes_cipher_core_round
  import aes_cipher_core_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] state_in,
  input  logic [AES_BLOCK_W-1:0] round_key,
  input  logic                   final_round,
  output logic [AES_BLOCK_W-1:0] state_out
);

  logic [AES_BLOCK_W-1:0] sub_blk;
  logic [AES_BLOCK_W-1:0] shift_blk;
  logic [AES_BLOCK_W-1:0] mix_blk;

  // byte i sits at bits [127-8i -: 8]; byte i is row i%4, column i/4
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_cipher_core_sbox u_sbox (
      .in_byte  (state_in[AES_BLOCK_W-1-8*i -: 8]),
      .out_byte (sub_blk[AES_BLOCK_W-1-8*i -: 8])
    );
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    // row r rotates left by r columns
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shift_blk[AES_BLOCK_W-1-8*(r+4*c) -: 8] =
             sub_blk[AES_BLOCK_W-1-8*(r+4*((c+r)%4)) -: 8];
    end
    assign mix_blk[AES_BLOCK_W-1-32*c -: 32] = mix_column(shift_blk[AES_BLOCK_W-1-32*c -: 32]);
  end

  // the last round skips MixColumns
  assign state_out = (final_round ? shift_blk : mix_blk) ^ round_key;

endmodule

// File: rtl/aes_cipher_core_sbox.sv
// rtl/aes_cipher_core_sbox.sv - AES forward S-box (GF inverse plus affine map)
module aes_cipher_core_sbox
  import aes_cipher_core_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  logic [7:0] inv;

  assign inv = gf_inv(in_byte);

  // affine map: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
  assign out_byte = inv
                  ^ {inv[6:0], inv[7]}
                  ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]}
                  ^ 8'h63;

endmodule

// File: rtl/aes_cipher_core.sv
// rtl/aes_cipher_core.sv - iterative AES-128 encryption core reading round keys from key_sram
module aes_cipher_core
  import aes_cipher_core_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic             clk,
  input  logic             reset,
  aes_cipher_core_if.slave bus
);

  aes_state_e             st_q, st_d;
  logic [AES_ADDR_W-1:0]  cnt_q, cnt_d;
  logic [AES_BLOCK_W-1:0] blk_q, blk_d;
  logic [AES_BLOCK_W-1:0] round_out;
  logic                   accept;

  // key_ready only matters at the accept point; later drops do not disturb a running block
  assign bus.in_ready  = (st_q == ST_IDLE) && bus.key_ready && !reset;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.rk_addr   = cnt_q;
  assign bus.busy      = (st_q != ST_IDLE);
  assign bus.out_valid = (st_q == ST_DONE);
  assign bus.out_block = (st_q == ST_DONE) ? blk_q : '0;

  aes_cipher_core_round u_round (
    .state_in    (blk_q),
    .round_key   (bus.rk_data),
    .final_round (st_q == ST_FINAL),
    .state_out   (round_out)
  );

  // state, round counter and block register; reset discards any partial block
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= ST_IDLE;
      cnt_q <= '0;
      blk_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      blk_q <= blk_d;
    end
  end

  // next state; cnt leads the round by one cycle to cover the SRAM read latency
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    blk_d = blk_q;
    case (st_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          blk_d = bus.in_block;
          cnt_d = AES_ADDR_W'(1);
          st_d  = ST_ADDKEY;
        end
      end
      ST_ADDKEY: begin
        blk_d = blk_q ^ bus.rk_data;
        cnt_d = AES_ADDR_W'(2);
        st_d  = ST_ROUND;
      end
      ST_ROUND: begin
        blk_d = round_out;
        if (cnt_q == AES_ADDR_W'(NR)) begin
          cnt_d = '0;
          st_d  = ST_FINAL;
        end else begin
          cnt_d = cnt_q + AES_ADDR_W'(1);
        end
      end
      ST_FINAL: begin
        blk_d = round_out;
        cnt_d = '0;
        st_d  = ST_DONE;
      end
      ST_DONE: begin
        cnt_d = '0;
        if (bus.out_ready) st_d = ST_IDLE;
      end
      default: begin
        cnt_d = '0;
        st_d  = ST_IDLE;
      end
    endcase
  end

endmodule
